// File: rtl/dcd_scan_ctrl_if.sv
// dcd_scan_ctrl_if: request/response and decoder-tree signals of the decision-scan controller.
interface dcd_scan_ctrl_if #(
    parameter int NUM_VARS_OF_BIN = 32,
    parameter int NUM_GROUP       = 8,
    parameter int WIDTH_VAR       = 5,
    parameter int WIDTH_LVL       = 16
);
    localparam int NUM_GRPS  = NUM_VARS_OF_BIN / NUM_GROUP;
    localparam int WIDTH_GRP = (NUM_GRPS > 1) ? $clog2(NUM_GRPS) : 1;

    logic                 start_decision_i;
    logic [WIDTH_LVL-1:0] cur_lvl_i;
    logic [WIDTH_GRP-1:0] group_idx_o;
    logic [1:0]           lock_cnt_o;
    logic [1:0]           lock_cnt_i;
    logic [NUM_GROUP-1:0] index_i;
    logic                 done_decision_o;
    logic                 found_o;
    logic [WIDTH_VAR-1:0] var_idx_o;
    logic [WIDTH_LVL-1:0] dcd_lvl_o;
    logic                 value_o;
    logic                 busy_o;

    modport slave (
        input  start_decision_i, cur_lvl_i, lock_cnt_i, index_i,
        output group_idx_o, lock_cnt_o, done_decision_o, found_o, var_idx_o, dcd_lvl_o, value_o, busy_o
    );

    modport master (
        output start_decision_i, cur_lvl_i, lock_cnt_i, index_i,
        input  group_idx_o, lock_cnt_o, done_decision_o, found_o, var_idx_o, dcd_lvl_o, value_o, busy_o
    );
endinterface

// File: rtl/dcd_scan_ctrl.sv
// dcd_scan_ctrl: walks a bin through the free-variable decoder tree one group per cycle
// and emits the lowest free variable as a decision, or reports the bin fully assigned.
module dcd_scan_ctrl #(
    parameter int NUM_VARS_OF_BIN = 32,
    parameter int NUM_GROUP       = 8,
    parameter int WIDTH_VAR       = 5,
    parameter int WIDTH_LVL       = 16
) (
    input logic            clk,
    input logic            rst,
    dcd_scan_ctrl_if.slave bus
);
    localparam int NUM_GRPS  = NUM_VARS_OF_BIN / NUM_GROUP;
    localparam int WIDTH_GRP = (NUM_GRPS > 1) ? $clog2(NUM_GRPS) : 1;
    localparam int WIDTH_POS = (NUM_GROUP > 1) ? $clog2(NUM_GROUP) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t               state_q, state_d;
    logic [WIDTH_GRP-1:0] grp_q, grp_d;
    logic [1:0]           lock_q, lock_d;
    logic [WIDTH_LVL-1:0] lvl_q, lvl_d;
    logic [WIDTH_VAR-1:0] var_q, var_d;
    logic [WIDTH_LVL-1:0] dlvl_q, dlvl_d;
    logic                 found_q, found_d;
    logic [WIDTH_POS-1:0] pos;

    // Scanning downward leaves the lowest set bit, so the lowest variable wins.
    always_comb begin
        pos = '0;
        for (int i = NUM_GROUP - 1; i >= 0; i--)
            if (bus.index_i[i]) pos = WIDTH_POS'(i);
    end

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        lock_d  = lock_q;
        lvl_d   = lvl_q;
        var_d   = var_q;
        dlvl_d  = dlvl_q;
        found_d = found_q;
        case (state_q)
            IDLE: if (bus.start_decision_i) begin
                grp_d   = '0;
                lock_d  = '0;
                lvl_d   = bus.cur_lvl_i;
                state_d = SCAN;
            end
            SCAN: if (|bus.index_i) begin
                var_d   = WIDTH_VAR'(grp_q) * WIDTH_VAR'(NUM_GROUP) + WIDTH_VAR'(pos);
                found_d = 1'b1;
                dlvl_d  = lvl_q + WIDTH_LVL'(1);
                state_d = DONE;
            end else if (grp_q == WIDTH_GRP'(NUM_GRPS - 1)) begin
                found_d = 1'b0;
                state_d = DONE;
            end else begin
                grp_d  = grp_q + WIDTH_GRP'(1);
                lock_d = bus.lock_cnt_i;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grp_q   <= '0;
            lock_q  <= '0;
            lvl_q   <= '0;
            var_q   <= '0;
            dlvl_q  <= '0;
            found_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            lock_q  <= lock_d;
            lvl_q   <= lvl_d;
            var_q   <= var_d;
            dlvl_q  <= dlvl_d;
            found_q <= found_d;
        end
    end

    assign bus.group_idx_o     = grp_q;
    assign bus.lock_cnt_o      = lock_q;
    assign bus.done_decision_o = (state_q == DONE);
    assign bus.busy_o          = (state_q != IDLE);
    assign bus.found_o         = found_q;
    assign bus.var_idx_o       = var_q;
    assign bus.dcd_lvl_o       = dlvl_q;
    assign bus.value_o         = 1'b0;
endmodule

// File: tb/tb_dcd_scan_ctrl.sv
// tb_dcd_scan_ctrl: directed and randomized decisions against a table-driven decoder tree
// and a whole-bin reference (lowest free variable, latency from its group).
module tb_dcd_scan_ctrl;
    localparam int NV = 32;
    localparam int NG = 8;
    localparam int NGRPS = NV / NG;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] free_vec = '0;
    logic [1:0]  lk [NGRPS];
    int          n_cmp = 0;
    int          n_err = 0;
    int          prev_var = 0;
    logic [15:0] prev_lvl = '0;

    dcd_scan_ctrl_if bus ();

    dcd_scan_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    assign bus.index_i    = free_vec[bus.group_idx_o * NG +: NG];
    assign bus.lock_cnt_i = lk[bus.group_idx_o];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_grp"},   32'(bus.group_idx_o), 0);
        check({tag, "_lock"},  32'(bus.lock_cnt_o), 0);
        check({tag, "_done"},  32'(bus.done_decision_o), 0);
        check({tag, "_found"}, 32'(bus.found_o), 0);
        check({tag, "_var"},   32'(bus.var_idx_o), 0);
        check({tag, "_lvl"},   32'(bus.dcd_lvl_o), 0);
        check({tag, "_value"}, 32'(bus.value_o), 0);
        check({tag, "_busy"},  32'(bus.busy_o), 0);
    endtask

    task automatic run_scan(input logic [15:0] lvl, input bit busy_start);
        int          first;
        int          last_g;
        bit          exp_found;
        logic [15:0] nxt;
        first = -1;
        for (int i = NV - 1; i >= 0; i--) if (free_vec[i]) first = i;
        exp_found = (first >= 0);
        last_g = exp_found ? first / NG : NGRPS - 1;
        nxt = lvl + 16'd1;
        if (exp_found) begin
            prev_var = first;
            prev_lvl = nxt;
        end
        bus.start_decision_i = 1'b1;
        bus.cur_lvl_i = lvl;
        tick();
        bus.start_decision_i = 1'b0;
        bus.cur_lvl_i = 16'($urandom);
        for (int g = 0; g <= last_g; g++) begin
            check("scan_busy", 32'(bus.busy_o), 1);
            check("scan_done", 32'(bus.done_decision_o), 0);
            check("scan_grp",  32'(bus.group_idx_o), 32'(g));
            check("scan_lock", 32'(bus.lock_cnt_o), (g == 0) ? 0 : 32'(lk[g-1]));
            if (busy_start && g == 0) bus.start_decision_i = 1'b1;
            tick();
            bus.start_decision_i = 1'b0;
        end
        check("done_pulse", 32'(bus.done_decision_o), 1);
        check("done_busy",  32'(bus.busy_o), 1);
        check("done_found", 32'(bus.found_o), 32'(exp_found));
        check("done_var",   32'(bus.var_idx_o), 32'(prev_var));
        check("done_lvl",   32'(bus.dcd_lvl_o), 32'(prev_lvl));
        check("done_value", 32'(bus.value_o), 0);
        if (busy_start) bus.start_decision_i = 1'b1;
        tick();
        bus.start_decision_i = 1'b0;
        check("idle_done", 32'(bus.done_decision_o), 0);
        check("idle_busy", 32'(bus.busy_o), 0);
        tick();
        check("idle2_done",  32'(bus.done_decision_o), 0);
        check("idle2_busy",  32'(bus.busy_o), 0);
        check("hold_found",  32'(bus.found_o), 32'(exp_found));
        check("hold_var",    32'(bus.var_idx_o), 32'(prev_var));
        check("hold_lvl",    32'(bus.dcd_lvl_o), 32'(prev_lvl));
    endtask

    initial begin
        bus.start_decision_i = 1'b0;
        bus.cur_lvl_i = '0;
        for (int i = 0; i < NGRPS; i++) lk[i] = 2'd0;
        repeat (3) tick();
        check_reset_vals("rst");
        rst = 1'b0;
        tick();
        check_reset_vals("post_rst");

        free_vec = 32'h0000_0014;
        run_scan(16'd3, 1'b0);

        free_vec = 32'h0080_0000;
        lk[0] = 2'd1;
        lk[1] = 2'd2;
        lk[2] = 2'd3;
        run_scan(16'd10, 1'b0);

        free_vec = 32'h0;
        run_scan(16'd77, 1'b0);

        free_vec = 32'h8000_0000;
        run_scan(16'hFFFF, 1'b0);

        free_vec = 32'h0100_0000;
        run_scan(16'd5, 1'b1);

        // Abort in the second SCAN cycle; the aborted scan must leave no trace.
        free_vec = 32'h4000_0000;
        bus.start_decision_i = 1'b1;
        bus.cur_lvl_i = 16'd9;
        tick();
        bus.start_decision_i = 1'b0;
        tick();
        check("abort_grp", 32'(bus.group_idx_o), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals("abort");
        prev_var = 0;
        prev_lvl = '0;
        for (int c = 0; c < 4; c++) begin
            check("abort_nodone", 32'(bus.done_decision_o), 0);
            tick();
        end
        run_scan(16'd20, 1'b0);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: free_vec = '0;
                1: free_vec = 32'(1) << $urandom_range(0, NV - 1);
                2: free_vec = $urandom & $urandom & $urandom;
                default: free_vec = $urandom & (32'hFF << (NG * $urandom_range(0, NGRPS - 1)));
            endcase
            for (int i = 0; i < NGRPS; i++) lk[i] = 2'($urandom);
            run_scan(16'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
